// File: rtl/stream_convolver.sv
// Streaming 2-D convolver: a K-column sliding window feeds N_LANES kernel sums per column.
// Two-stage pipeline (products, then sum/shift/clamp) under valid/ready flow control.
module stream_convolver #(
    parameter int N_LANES      = 4,
    parameter int KERNEL_WIDTH = 3,
    parameter int NB_PIXEL     = 8,
    parameter int NB_COEFF     = 8,
    parameter int NB_FRAC      = 6,
    localparam int K           = KERNEL_WIDTH,
    localparam int KK          = K * K,
    localparam int NB_COL      = (N_LANES + K - 1) * NB_PIXEL,
    localparam int NB_OUT      = N_LANES * NB_PIXEL,
    localparam int NB_ADDR     = (KK > 1) ? $clog2(KK) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [NB_COL-1:0]          i_data,
    input  logic                       i_valid,
    input  logic                       i_sof,
    output logic                       o_ready,
    input  logic                       i_coeff_we,
    input  logic [NB_ADDR-1:0]         i_coeff_addr,
    input  logic signed [NB_COEFF-1:0] i_coeff_data,
    output logic [NB_OUT-1:0]          o_data,
    output logic                       o_valid,
    input  logic                       i_ready
);

    localparam int NB_PROD = NB_PIXEL + NB_COEFF + 1;
    localparam int NB_ACC  = NB_PROD + $clog2(KK);
    localparam int NB_CNT  = $clog2(K + 1);
    localparam int CENTER  = (K / 2) * K + K / 2;

    localparam logic [NB_CNT-1:0]          CNT_FULL = NB_CNT'(K);
    localparam logic signed [NB_COEFF-1:0] COEF_ONE = NB_COEFF'(1 << NB_FRAC);
    localparam logic signed [NB_ACC-1:0]   PIX_MAX  = NB_ACC'((1 << NB_PIXEL) - 1);

    logic advance;
    logic accept;
    logic launch;

    logic [NB_COL-1:0]          win_q   [K];
    logic [NB_COL-1:0]          win_d   [K];
    logic [NB_CNT-1:0]          cnt_q;
    logic [NB_CNT-1:0]          cnt_d;
    logic signed [NB_COEFF-1:0] coeff_q [KK];
    logic signed [NB_COEFF-1:0] coeff_d [KK];
    logic signed [NB_PROD-1:0]  prod_q  [N_LANES][KK];
    logic signed [NB_PROD-1:0]  prod_d  [N_LANES][KK];
    logic                       s1_valid_q;
    logic                       s1_valid_d;
    logic [NB_OUT-1:0]          o_data_q;
    logic [NB_OUT-1:0]          o_data_d;
    logic                       o_valid_q;
    logic                       o_valid_d;

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    function automatic logic signed [NB_PROD-1:0] mul(
        input logic [NB_PIXEL-1:0]        px,
        input logic signed [NB_COEFF-1:0] cf
    );
        logic signed [NB_PROD-1:0] a;
        logic signed [NB_PROD-1:0] b;
        a = NB_PROD'($signed({1'b0, px}));
        b = NB_PROD'(cf);
        return a * b;
    endfunction

    function automatic logic [NB_PIXEL-1:0] lane_out(
        input logic signed [NB_PROD-1:0] p [KK]
    );
        logic signed [NB_ACC-1:0] acc;
        logic signed [NB_ACC-1:0] sh;
        acc = '0;
        for (int t = 0; t < KK; t++) begin
            acc = acc + NB_ACC'(p[t]);
        end
        sh = acc >>> NB_FRAC;
        if (sh[NB_ACC-1]) begin
            return '0;
        end
        if (sh > PIX_MAX) begin
            return '1;
        end
        return sh[NB_PIXEL-1:0];
    endfunction

    always_comb begin
        advance = !o_valid_q || i_ready;
        accept  = i_valid && advance;
        win_d   = win_q;
        cnt_d   = cnt_q;
        if (accept) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[c] = win_q[c + 1];
            end
            win_d[K - 1] = i_data;
            if (i_sof) begin
                cnt_d = NB_CNT'(1);
            end else if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + NB_CNT'(1);
            end
        end
        launch = accept && (cnt_d == CNT_FULL);
    end

    always_comb begin
        coeff_d = coeff_q;
        if (i_coeff_we && (int'(i_coeff_addr) < KK)) begin
            coeff_d[i_coeff_addr] = i_coeff_data;
        end
    end

    // Products use the pre-write coefficients, so a same-edge write hits later columns only.
    always_comb begin
        s1_valid_d = s1_valid_q;
        prod_d     = prod_q;
        if (advance) begin
            s1_valid_d = launch;
            for (int i = 0; i < N_LANES; i++) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        prod_d[i][r*K+c] = mul(
                            win_d[c][(i+r)*NB_PIXEL +: NB_PIXEL],
                            coeff_q[r*K+c]);
                    end
                end
            end
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        if (advance) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < N_LANES; i++) begin
                    o_data_d[i*NB_PIXEL +: NB_PIXEL] = lane_out(prod_q[i]);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            win_q      <= '{default: '0};
            cnt_q      <= '0;
            for (int a = 0; a < KK; a++) begin
                coeff_q[a] <= (a == CENTER) ? COEF_ONE : '0;
            end
            prod_q     <= '{default: '0};
            s1_valid_q <= 1'b0;
            o_data_q   <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            coeff_q    <= coeff_d;
            prod_q     <= prod_d;
            s1_valid_q <= s1_valid_d;
            o_data_q   <= o_data_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign o_ready = advance;
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

endmodule

// File: doc/stream_convolver.md
STREAM_CONVOLVER -- requirements
Module: stream_convolver

Interface
REQ-001 SHALL have parameter N_LANES, default 4: output pixels produced per accepted column.
REQ-002 SHALL have parameter KERNEL_WIDTH, default 3: square kernel side K.
REQ-003 SHALL have parameters NB_PIXEL, default 8 (unsigned pixel), NB_COEFF, default 8 (signed coefficient), NB_FRAC, default 6 (coefficient fraction bits).
REQ-004 SHALL derive NB_COL = (N_LANES+K-1)*NB_PIXEL and NB_OUT = N_LANES*NB_PIXEL.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_data  in  NB_COL  one image column strip, pixel j at [j*NB_PIXEL +: NB_PIXEL], j=0 top.
REQ-008 i_valid  in  1  i_data valid; i_sof  in  1  column is first of a frame (qualified by i_valid).
REQ-009 o_ready  out  1  column accepted on edge where i_valid && o_ready.
REQ-010 i_coeff_we  in  1, i_coeff_addr  in  clog2(K*K), i_coeff_data  in  NB_COEFF: coefficient write port, addr = row*K + col.
REQ-011 o_data  out  NB_OUT  lane i at [i*NB_PIXEL +: NB_PIXEL]; o_valid  out  1; i_ready  in  1  downstream accept.

Function
REQ-012 SHALL hold the last K accepted columns in a window register; oldest column is kernel col 0, newest col K-1.
REQ-013 SHALL keep a column counter saturating at K; i_sof with acceptance sets counter to 1 (that column becomes col K-1, older columns ignored).
REQ-014 An accepted column SHALL launch a computation only when counter after acceptance equals K.
REQ-015 Lane i result SHALL be sum over r,c of pixel(row i+r, col c) * coeff[r*K+c], pixel zero-extended, full-precision accumulate (no overflow).
REQ-016 Result SHALL be arithmetic-shifted right by NB_FRAC (floor), then clamped to [0, 2^NB_PIXEL-1].
REQ-017 Pipeline SHALL be 2 stages: products registered, then sum/shift/clamp registered into o_data; o_valid rises 2 advancing cycles after acceptance.
REQ-018 Pipeline SHALL advance when !o_valid || i_ready; o_ready SHALL equal that condition; when stalled, o_data/o_valid and all stages hold.
REQ-019 o_data SHALL remain stable while o_valid && !i_ready; no result lost or duplicated under any backpressure pattern.
REQ-020 Coefficient write SHALL take effect for columns accepted on later edges; write and acceptance on same edge uses old coefficients.
REQ-021 i_sof SHALL not flush in-flight results; they are emitted in order.
REQ-022 i_sof, i_data ignored when i_valid=0; coefficient writes accepted regardless of stall.

Reset
REQ-023 On i_reset_n=0: o_valid=0, o_data=0, counter=0, window and pipeline registers=0, o_ready=1.
REQ-024 Coefficients SHALL reset to identity: center tap (K/2*K+K/2) = 1<<NB_FRAC, all others 0.
REQ-025 Reset mid-operation SHALL discard all in-flight results; first valid output after release needs K fresh columns.

Verification
REQ-026 Defaults, post-reset identity kernel, send columns A, B=0x060504030201, C -> exactly one o_valid, o_data=0x05040302, 2 cycles after C accepted, none after A or B.
REQ-027 All 9 coeffs=64, three columns all 0x10 -> o_data=0x90909090; same with 0x20 -> 0xFFFFFFFF (saturate).
REQ-028 Center coeff=-64 (0xC0), others 0, three columns of 0x40 -> o_data=0x00000000 (negative clamp).
REQ-029 i_ready=0, stream 6 columns continuous i_valid -> o_ready falls with o_valid held after pipeline fills; release i_ready -> 4 results in order, values match model, none lost.
REQ-030 After 4 columns, send i_sof column then 1 more -> no output for either; third column after i_sof yields output; then assert i_reset_n=0 mid-stream -> o_valid=0 immediately, coeffs back to identity.
